// File: rtl/reset_seq_gen.sv
// Multi-channel reset sequencer. It qualifies a synchronised PLL lock, then releases
// the reset channels in index order with programmable spacing.
//
// state | meaning
// HOLD  | all channels asserted; lock filter counting qualified-lock cycles
// WAIT  | lock qualified; counting INIT_DELAY before channel 0 release
// STEP  | releasing channels 1..NUM_CH-1, one every STAGE_DELAY cycles
// RUN   | every channel released; READY follows one cycle later
module reset_seq_gen #(
   parameter int NUM_CH       = 4,
   parameter int CNT_W        = 16,
   parameter int INIT_DELAY   = 400,
   parameter int STAGE_DELAY  = 16,
   parameter int LOCK_FILTER  = 8,
   parameter int ACTIVE_LEVEL = 0
) (
   input  logic              CLK,
   input  logic              RESETN,
   input  logic              LOCK,
   input  logic              SW_RST,
   output logic [NUM_CH-1:0] RESET_OUT,
   output logic              READY,
   output logic [1:0]        SEQ_STATE
);

   localparam int FILT_W = $clog2(LOCK_FILTER + 1);
   localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [NUM_CH-1:0] ASSERTED = (ACTIVE_LEVEL != 0) ? '1 : '0;

   // reject parameter sets that would make the counters wrap or the sequence empty
   if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
      $error("reset_seq_gen: NUM_CH must be 1..16");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("reset_seq_gen: CNT_W must be >= 1");
   end
   if (INIT_DELAY < 1 || STAGE_DELAY < 1 || LOCK_FILTER < 1) begin : g_bad_delay
      $error("reset_seq_gen: INIT_DELAY, STAGE_DELAY and LOCK_FILTER must be >= 1");
   end
   if (CNT_W < 31 && (INIT_DELAY >= (1 << CNT_W) || STAGE_DELAY >= (1 << CNT_W))) begin : g_bad_range
      $error("reset_seq_gen: delays must be < 2**CNT_W");
   end

   typedef enum logic [1:0] {
      S_HOLD = 2'd0,
      S_WAIT = 2'd1,
      S_STEP = 2'd2,
      S_RUN  = 2'd3
   } state_t;

   state_t              state_q, state_n;
   logic [1:0]          sync_q;
   logic                lock_s;
   logic                abort;
   logic [CNT_W-1:0]    cnt_q, cnt_n;
   logic [FILT_W-1:0]   filt_q, filt_n;
   logic [IDX_W-1:0]    idx_q, idx_n;
   logic [NUM_CH-1:0]   rel_q, rel_n;
   logic [NUM_CH-1:0]   out_q;
   logic                ready_q, ready_n;

   assign lock_s    = sync_q[1];
   assign abort     = !lock_s || SW_RST;
   assign rel_q     = out_q ^ ASSERTED;
   assign RESET_OUT = out_q;
   assign READY     = ready_q;
   assign SEQ_STATE = state_q;

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         sync_q  <= '0;
         state_q <= S_HOLD;
         cnt_q   <= '0;
         filt_q  <= '0;
         idx_q   <= '0;
         out_q   <= ASSERTED;
         ready_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[0], LOCK};
         state_q <= state_n;
         cnt_q   <= cnt_n;
         filt_q  <= filt_n;
         idx_q   <= idx_n;
         out_q   <= rel_n ^ ASSERTED;
         ready_q <= ready_n;
      end
   end

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      filt_n  = filt_q;
      idx_n   = idx_q;
      rel_n   = rel_q;
      ready_n = 1'b0;

      if (abort) begin
         state_n = S_HOLD;
         cnt_n   = '0;
         filt_n  = '0;
         idx_n   = '0;
         rel_n   = '0;
      end else begin
         case (state_q)
            S_HOLD: begin
               rel_n = '0;
               if (filt_q == FILT_W'(LOCK_FILTER)) begin
                  state_n = S_WAIT;
                  cnt_n   = '0;
                  filt_n  = '0;
               end else begin
                  filt_n = filt_q + FILT_W'(1);
               end
            end
            S_WAIT: begin
               if (cnt_q == CNT_W'(INIT_DELAY - 1)) begin
                  rel_n[0] = 1'b1;
                  cnt_n    = '0;
                  if (NUM_CH == 1) begin
                     state_n = S_RUN;
                     idx_n   = '0;
                  end else begin
                     state_n = S_STEP;
                     idx_n   = IDX_W'(1);
                  end
               end else begin
                  cnt_n = cnt_q + CNT_W'(1);
               end
            end
            S_STEP: begin
               if (cnt_q == CNT_W'(STAGE_DELAY - 1)) begin
                  for (int i = 0; i < NUM_CH; i++) begin
                     if (idx_q == IDX_W'(i)) rel_n[i] = 1'b1;
                  end
                  cnt_n = '0;
                  if (idx_q == IDX_W'(NUM_CH - 1)) begin
                     state_n = S_RUN;
                  end else begin
                     idx_n = idx_q + IDX_W'(1);
                  end
               end else begin
                  cnt_n = cnt_q + CNT_W'(1);
               end
            end
            S_RUN: begin
               ready_n = 1'b1;
            end
            default: begin
               state_n = S_HOLD;
               rel_n   = '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_reset_seq_gen.sv
// Directed bench for reset_seq_gen: expected output changes are queued with their
// edge number relative to a reference edge and checked as the DUT produces them.
module tb_reset_seq_gen;

   localparam int LF  = 8;
   localparam int ID  = 400;
   localparam int SD  = 16;
   localparam int NCH = 4;
   localparam int T0  = 2 + LF + ID;

   logic       CLK = 1'b0;
   logic       RESETN = 1'b0;
   logic       LOCK = 1'b0;
   logic       SW_RST = 1'b0;
   logic [3:0] reset_out;
   logic       ready;
   logic [1:0] seq_state;
   logic [0:0] reset_out2;
   logic       ready2;
   logic [1:0] seq_state2;

   always #5 CLK = ~CLK;

   int edge_n = 0;
   int base = 0;
   always @(posedge CLK) edge_n <= edge_n + 1;

   reset_seq_gen #(
      .NUM_CH(NCH), .CNT_W(16), .INIT_DELAY(ID), .STAGE_DELAY(SD),
      .LOCK_FILTER(LF), .ACTIVE_LEVEL(0)
   ) dut (
      .CLK(CLK), .RESETN(RESETN), .LOCK(LOCK), .SW_RST(SW_RST),
      .RESET_OUT(reset_out), .READY(ready), .SEQ_STATE(seq_state)
   );

   reset_seq_gen #(
      .NUM_CH(1), .CNT_W(16), .INIT_DELAY(ID), .STAGE_DELAY(SD),
      .LOCK_FILTER(LF), .ACTIVE_LEVEL(1)
   ) dut2 (
      .CLK(CLK), .RESETN(RESETN), .LOCK(LOCK), .SW_RST(SW_RST),
      .RESET_OUT(reset_out2), .READY(ready2), .SEQ_STATE(seq_state2)
   );

   typedef struct {
      int         edge_no;
      logic [3:0] out;
      logic       rdy;
      logic [1:0] st;
   } ev_t;

   ev_t        exp_q[$];
   int         n_assert = 0;
   int         n_fail = 0;
   logic [6:0] last;

   // single-channel, active-high instance: record when it releases and becomes ready
   bit mon2_en = 1'b0;
   int r2_rel, r2_rdy;
   bit step2;
   always @(negedge CLK) begin
      if (!mon2_en) begin
         r2_rel = -1;
         r2_rdy = -1;
         step2  = 1'b0;
      end else begin
         if (r2_rel < 0 && reset_out2 == 1'b0) r2_rel = edge_n - base - 1;
         if (r2_rdy < 0 && ready2 == 1'b1) r2_rdy = edge_n - base - 1;
         if (seq_state2 == 2'd2) step2 = 1'b1;
      end
   end

   function automatic logic [6:0] snapshot();
      return {reset_out, ready, seq_state};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push_ev(input int e, input logic [3:0] o, input logic r, input logic [1:0] s);
      ev_t ev;
      ev.edge_no = e;
      ev.out     = o;
      ev.rdy     = r;
      ev.st      = s;
      exp_q.push_back(ev);
   endtask

   // full release sequence, shifted by off edges from the lock-at-cycle-0 reference
   task automatic push_seq(input int off);
      logic [4:0] m;
      push_ev(2 + LF + off, 4'h0, 1'b0, 2'd1);
      for (int i = 0; i < NCH; i++) begin
         m = (5'd1 << (i + 1)) - 5'd1;
         push_ev(T0 + i * SD + off, m[3:0], 1'b0, (i == NCH - 1) ? 2'd3 : 2'd2);
      end
      push_ev(T0 + (NCH - 1) * SD + 1 + off, 4'hF, 1'b1, 2'd3);
   endtask

   task automatic wait_event(input string tag);
      ev_t        e;
      int         n;
      logic [6:0] cur;
      e = exp_q.pop_front();
      n = 0;
      do begin
         @(negedge CLK);
         n++;
         cur = snapshot();
      end while (cur === last && n < 1000);
      chk({tag, "_change"}, {31'd0, cur !== last}, 32'd1);
      last = cur;
      chk({tag, "_edge"}, edge_n - base - 1, e.edge_no);
      chk({tag, "_out"}, {28'd0, reset_out}, {28'd0, e.out});
      chk({tag, "_ready"}, {31'd0, ready}, {31'd0, e.rdy});
      chk({tag, "_state"}, {30'd0, seq_state}, {30'd0, e.st});
   endtask

   task automatic expect_quiet(input string tag, input int n);
      bit changed;
      changed = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         if (snapshot() !== last) changed = 1'b1;
      end
      chk(tag, {31'd0, changed}, 32'd0);
   endtask

   initial begin
      // reset state with lock already present
      RESETN = 1'b0; LOCK = 1'b1; SW_RST = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_out", {28'd0, reset_out}, 32'h0);
      chk("rst_ready", {31'd0, ready}, 32'd0);
      chk("rst_state", {30'd0, seq_state}, 32'd0);
      chk("rst_out2", {31'd0, reset_out2}, 32'd1);

      // power-up sequence at default timing
      RESETN = 1'b1; base = edge_n; last = snapshot(); mon2_en = 1'b1;
      push_seq(0);
      for (int i = 0; i < 6; i++) wait_event($sformatf("pwr%0d", i));
      chk("ch1_rel_edge", r2_rel, T0);
      chk("ch1_ready_edge", r2_rdy, T0 + 1);
      chk("ch1_no_step", {31'd0, step2}, 32'd0);
      mon2_en = 1'b0;

      // lock loss in RUN, then lock return
      LOCK = 1'b0; base = edge_n;
      push_ev(2, 4'h0, 1'b0, 2'd0);
      wait_event("lockloss");
      expect_quiet("lockloss_hold", 20);
      LOCK = 1'b1; base = edge_n;
      push_seq(0);
      for (int i = 0; i < 3; i++) wait_event($sformatf("relock%0d", i));
      exp_q.delete();

      // one-cycle software reset in STEP just after channel 1 released
      SW_RST = 1'b1; base = edge_n;
      push_ev(0, 4'h0, 1'b0, 2'd0);
      wait_event("swpulse");
      SW_RST = 1'b0;
      push_seq(-1);
      for (int i = 0; i < 6; i++) wait_event($sformatf("swrst%0d", i));

      // software reset held: must stay in HOLD
      SW_RST = 1'b1; base = edge_n;
      push_ev(0, 4'h0, 1'b0, 2'd0);
      wait_event("swhold");
      expect_quiet("swhold_quiet", 600);
      SW_RST = 1'b0; base = edge_n;
      push_seq(-2);
      for (int i = 0; i < 6; i++) wait_event($sformatf("swrel%0d", i));

      // short lock pulse must not qualify; filter restarts on the final rise
      RESETN = 1'b0; LOCK = 1'b0;
      repeat (3) @(negedge CLK);
      RESETN = 1'b1; last = snapshot();
      expect_quiet("nolock_quiet", 10);
      LOCK = 1'b1;
      expect_quiet("pulse_quiet", 5);
      LOCK = 1'b0;
      expect_quiet("pulse_after", 30);
      LOCK = 1'b1; base = edge_n;
      push_seq(0);
      for (int i = 0; i < 6; i++) wait_event($sformatf("glitch%0d", i));

      // asynchronous RESETN pulse in WAIT
      SW_RST = 1'b1; base = edge_n;
      push_ev(0, 4'h0, 1'b0, 2'd0);
      wait_event("towait_abort");
      SW_RST = 1'b0;
      push_ev(2 + LF - 1, 4'h0, 1'b0, 2'd1);
      wait_event("towait");
      repeat (50) @(negedge CLK);
      #2 RESETN = 1'b0;
      #1;
      chk("async_wait_state", {30'd0, seq_state}, 32'd0);
      chk("async_wait_out", {28'd0, reset_out}, 32'h0);
      repeat (2) @(negedge CLK);
      RESETN = 1'b1; base = edge_n; last = snapshot();
      push_seq(0);
      for (int i = 0; i < 6; i++) wait_event($sformatf("after_async%0d", i));

      // asynchronous RESETN in RUN: outputs assert with no clock edge
      @(negedge CLK);
      #2 RESETN = 1'b0;
      #1;
      chk("async_run_out", {28'd0, reset_out}, 32'h0);
      chk("async_run_ready", {31'd0, ready}, 32'd0);
      chk("async_run_state", {30'd0, seq_state}, 32'd0);
      chk("async_run_out2", {31'd0, reset_out2}, 32'd1);
      chk("queue_empty", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
